// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1001_0000;
  localparam int          DEFAULT_DATA_WIDTH = 32;
  localparam int          STRB_W             = DEFAULT_DATA_WIDTH / 8;
  // Wide enough for WAIT_STATES up to 15.
  localparam int          CNT_W              = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with per-byte-lane write enables, synchronous write and
// combinational read of the addressed word.
module dmem_byte_ram
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 256,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int LANES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [LANES-1:0]      wstrb_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // No reset: the array contents survive a core reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's lw/sw port: one request, WAIT_STATES
// stall cycles, one response pulse. Define DMEM_RESP_ADDR_CHECK_EN for address errors.
module data_mem_responder
  import dmem_resp_pkg::*;
#(
  parameter int          DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [31:0]             req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam int SW    = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  enter_resp;
  logic                  cur_write, cur_err, ram_we;
  logic [31:0]           cur_addr, cur_offset;
  logic [DATA_WIDTH-1:0] cur_wdata, ram_rdata;
  logic [SW-1:0]         cur_wstrb;
  logic [IDX_W-1:0]      cur_idx;
  logic                  unused_offset_bits;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    req_ready_o = 1'b0;
    enter_resp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access completes on the accept edge, so the
  // live request must be used before it has been captured.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = req_write_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
      cur_wstrb = req_wstrb_i;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
    end
  end

  assign cur_offset         = cur_addr - BASE_ADDR;
  assign cur_idx            = cur_offset[IDX_W+1:2];
  assign unused_offset_bits = ^{cur_offset[31:IDX_W+2], cur_offset[1:0]};

`ifdef DMEM_RESP_ADDR_CHECK_EN
  assign cur_err = (cur_offset >= 32'(4 * MEMORY_DEPTH)) || (cur_addr[1:0] != 2'b00);
`else
  assign cur_err = 1'b0;
`endif

  assign ram_we = enter_resp && cur_write && !cur_err;

  dmem_byte_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEMORY_DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .wstrb_i(cur_wstrb),
    .addr_i (cur_idx),
    .wdata_i(cur_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    rsp_valid_d = enter_resp;
    rsp_err_d   = enter_resp && cur_err;
    rsp_rdata_d = '0;
    if (enter_resp && !cur_write && !cur_err) begin
      rsp_rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = req_valid_i & ~rsp_valid_o;

endmodule
